mc_path_feeder: RTL and testbench

- Path-sample source for the Monte Carlo option-pricing core. It is the transmitter side of the core's path/start/resend interface.
- Buffers N simulated price paths over DAY time steps, loaded from the path generator. Streams them to the core one sample per cycle, last day first, as LSM backward induction requires.
- Each day is sent twice: once for regression accumulation, and again when the core raises resend for the cash-flow update pass.

---
 rtl/mc_path_feeder_if.sv | 23 ++
 rtl/mc_path_feeder.sv | 150 +++++++++++++++
 tb/tb_mc_path_feeder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_path_feeder_if.sv
// Core-side stream interface of the Monte Carlo path feeder.
// master = feeder (drives samples), slave = pricing core (drives resend).
// FEEDER_READY_EN adds the path_ready back-pressure signal.
interface mc_path_feeder_if #(
    parameter int WIDTH = 12,
    parameter int DAY_W = 3
);
    logic             start;
    logic [WIDTH-1:0] path;
    logic             path_valid;
    logic             resend;
    logic [DAY_W-1:0] day;
    logic             done;
`ifdef FEEDER_READY_EN
    logic             path_ready;

    modport master (output start, path, path_valid, day, done, input resend, path_ready);
    modport slave  (input start, path, path_valid, day, done, output resend, path_ready);
`else
    modport master (output start, path, path_valid, day, done, input resend);
    modport slave  (input start, path, path_valid, day, done, output resend);
`endif
endinterface

// File: rtl/mc_path_feeder.sv
// Monte Carlo path feeder: buffers N*DAY price samples and streams each day
// twice to the LSM core, last day first (regression pass, then resend pass).
// Optional macro FEEDER_READY_EN adds path_ready back-pressure on the stream.
module mc_path_feeder #(
    parameter int N     = 256,
    parameter int DAY   = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             load_full,
    input  logic             go,
    output logic             err,
    mc_path_feeder_if.master core
);
    localparam int IW    = $clog2(N);
    localparam int DW    = (DAY > 1) ? $clog2(DAY) : 1;
    localparam int AW    = DW + IW;
    localparam int DEPTH = N * DAY;

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_PASS1, S_WAIT_RS, S_PASS2, S_HOLD, S_FIN
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    day_q, day_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             load_full_q, load_full_d;
    logic             err_q, err_d;
    logic             path_valid_q, path_valid_d;
    logic [WIDTH-1:0] path_q;
    logic             rd_en, we, ready, adv;
    logic [AW-1:0]    rd_addr;

`ifdef FEEDER_READY_EN
    assign ready = core.path_ready;
`else
    assign ready = 1'b1;
`endif

    // The output register may take a new sample when empty or being consumed.
    // Without back-pressure this is always true, giving the plain 1-cycle stream.
    assign adv     = !path_valid_q || ready;
    assign rd_addr = {day_q, idx_q};
    assign we      = wr_en && !rst && (state_q == S_IDLE) && !load_full_q;

    // Next-state, load pointer, error and stream-advance decisions
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        day_d        = day_q;
        wr_ptr_d     = wr_ptr_q;
        load_full_d  = load_full_q;
        err_d        = err_q;
        rd_en        = 1'b0;
        path_valid_d = adv ? 1'b0 : path_valid_q;

        if (wr_en) begin
            if (state_q != S_IDLE) begin
                err_d = 1'b1;
            end else if (!load_full_q) begin
                if (wr_ptr_q == AW'(DEPTH - 1)) load_full_d = 1'b1;
                else                            wr_ptr_d    = wr_ptr_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (go && load_full_q) state_d = S_ARM;
            end
            S_ARM: begin
                if (core.resend) err_d = 1'b1;
                idx_d   = '0;
                state_d = S_PASS1;
            end
            S_PASS1, S_PASS2: begin
                if (state_q == S_PASS1 && core.resend) err_d = 1'b1;
                if (adv) begin
                    rd_en        = 1'b1;
                    path_valid_d = 1'b1;
                    idx_d        = idx_q + 1'b1;
                    if (idx_q == IW'(N - 1))
                        state_d = (state_q == S_PASS1) ? S_WAIT_RS : S_HOLD;
                end
            end
            S_WAIT_RS: begin
                if (core.resend) begin
                    idx_d   = '0;
                    state_d = S_PASS2;
                end
            end
            S_HOLD: begin
                if (!core.resend) begin
                    if (day_q != '0) begin
                        day_d   = day_q - 1'b1;
                        state_d = S_ARM;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                day_d   = DW'(DAY - 1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers plus the synchronous read port feeding path
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            day_q        <= DW'(DAY - 1);
            wr_ptr_q     <= '0;
            load_full_q  <= 1'b0;
            err_q        <= 1'b0;
            path_valid_q <= 1'b0;
            path_q       <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            day_q        <= day_d;
            wr_ptr_q     <= wr_ptr_d;
            load_full_q  <= load_full_d;
            err_q        <= err_d;
            path_valid_q <= path_valid_d;
            if (rd_en) path_q <= mem[rd_addr];
        end
    end

    // Sample storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= wr_data;
    end

    assign load_full       = load_full_q;
    assign err             = err_q;
    assign core.start      = (state_q == S_ARM);
    assign core.done       = (state_q == S_FIN);
    assign core.path       = path_q;
    assign core.path_valid = path_valid_q;
    assign core.day        = day_q;
endmodule

// File: tb/tb_mc_path_feeder.sv
// Directed bench for mc_path_feeder with a sample scoreboard.
module tb_mc_path_feeder;
    localparam int N = 256;
    localparam int DAY = 8;
    localparam int WIDTH = 12;

    typedef struct { logic [WIDTH-1:0] p; logic [2:0] d; } samp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic go = 1'b0;
    logic resend = 1'b0;
    logic rdy = 1'b1;
    logic tog = 1'b0;
    logic load_full, err;

    int tests = 0;
    int fails = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int n_samp = 0;
    samp_t exp_q[$];

    mc_path_feeder_if #(.WIDTH(WIDTH), .DAY_W(3)) core ();
    assign core.resend = resend;
`ifdef FEEDER_READY_EN
    assign core.path_ready = rdy;
`endif

    mc_path_feeder #(.N(N), .DAY(DAY), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .load_full(load_full), .go(go), .err(err), .core(core)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic push_day(input int d);
        for (int i = 0; i < N; i++) begin
            samp_t s;
            s.p = WIDTH'((d * N + i) % 4096);
            s.d = 3'(d);
            exp_q.push_back(s);
        end
    endtask

    task automatic load(input int from, input int to);
        for (int a = from; a < to; a++) begin
            wr_en = 1'b1; wr_data = WIDTH'(a % 4096); tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || core.path_valid) && k < bound) begin tick(); k++; end
        chk("drain_in_time", (k < bound), 1);
    endtask

    // probe: 0 none, 1 resend during ARM, 2 wr_en during ARM
    task automatic run_full(input bit detail, input int probe, input bit go_wr);
        int s0 = start_cnt;
        int d0 = done_cnt;
        int n0 = n_samp;
        push_day(7);
        go = 1'b1;
        if (go_wr) begin wr_en = 1'b1; wr_data = 12'hABC; end
        tick();
        go = 1'b0; wr_en = 1'b0;
        chk("go_start", core.start, 1);
        chk("go_day", core.day, 7);
        chk("go_no_err", err, 0);
        if (detail) begin
            tick(); chk("pv_T2", core.path_valid, 0); chk("start_T2", core.start, 0);
            tick(); chk("pv_T3", core.path_valid, 1); chk("path_T3", core.path, 1792);
        end
        if (probe == 1) begin resend = 1'b1; tick(); resend = 1'b0; chk("err_resend", err, 1); end
        if (probe == 2) begin wr_en = 1'b1; wr_data = 12'h555; tick(); wr_en = 1'b0; chk("err_wr", err, 1); end
        for (int d = 7; d >= 0; d--) begin
            wait_drain(1200);
            chk("wait_rs_pv", core.path_valid, 0);
            push_day(d);
            resend = 1'b1; go = 1'b1;
            tick();
            go = 1'b0;
            if (detail && d == 7) begin
                chk("pv_R1", core.path_valid, 0);
                tick(); chk("pv_R2", core.path_valid, 1); chk("path_R2", core.path, 1792);
            end
            wait_drain(1200);
            tick(40);
            chk("hold_pv", core.path_valid, 0);
            chk("hold_starts", start_cnt - s0, 8 - d);
            resend = 1'b0;
            tick();
            if (d > 0) begin
                push_day(d - 1);
                chk("adv_start", core.start, 1);
                chk("adv_day", core.day, d - 1);
            end else begin
                chk("done_pulse", core.done, 1);
                tick();
                chk("done_clear", core.done, 0);
                chk("day_reset", core.day, 7);
            end
        end
        chk("run_starts", start_cnt - s0, 8);
        chk("run_dones", done_cnt - d0, 1);
        chk("run_samples", n_samp - n0, 16 * N);
        if (probe != 0) chk("err_sticky", err, 1);
    endtask

    // Monitor: ready pattern, pulse counters and scoreboard pops
    always @(negedge clk) begin
`ifdef FEEDER_READY_EN
        if (tog) rdy = ~rdy; else rdy = 1'b1;
`endif
        if (core.start) start_cnt++;
        if (core.done) done_cnt++;
        if (core.path_valid && rdy) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_sample: observed path %0d expected none", core.path);
            end
            if (exp_q.size() != 0) begin
                samp_t e;
                e = exp_q.pop_front();
                chk("sample_path", core.path, e.p);
                chk("sample_day", core.day, e.d);
                n_samp++;
            end
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        chk("rst_load_full", load_full, 0);
        chk("rst_start", core.start, 0);
        chk("rst_pv", core.path_valid, 0);
        chk("rst_done", core.done, 0);
        chk("rst_err", err, 0);
        chk("rst_day", core.day, 7);
        chk("rst_path", core.path, 0);

        // go with a partial load is ignored
        load(0, 100);
        go = 1'b1; tick(); go = 1'b0; tick(5);
        chk("part_starts", start_cnt, 0);
        chk("part_pv", core.path_valid, 0);
        chk("part_full", load_full, 0);
        load(100, N * DAY);
        chk("full", load_full, 1);
        wr_en = 1'b1; wr_data = 12'hFFF; tick(); wr_en = 1'b0;
        chk("full_wr_no_err", err, 0);

        run_full(1'b1, 0, 1'b0);
        run_full(1'b0, 1, 1'b1);

        // reset in the middle of a resend pass
        push_day(7);
        go = 1'b1; tick(); go = 1'b0;
        wait_drain(1200);
        push_day(7);
        resend = 1'b1; tick(60);
        chk("err_before_rst", err, 1);
        rst = 1'b1; tick();
        chk("mid_rst_pv", core.path_valid, 0);
        chk("mid_rst_full", load_full, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_day", core.day, 7);
        chk("mid_rst_start", core.start, 0);
        rst = 1'b0; resend = 1'b0;
        exp_q.delete();
        tick(2);

        load(0, N * DAY);
        chk("reload_full", load_full, 1);
        tog = 1'b1;
        run_full(1'b0, 2, 1'b0);
        tog = 1'b0;
        tick(3);
        chk("final_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
